// File: rtl/oam_dma_bus.sv
// OAM DMA engine and CPU/memory bus arbiter: forwards CPU accesses, owns the DMA register and copies DMA_LEN bytes to OAM.
// Optional macro OAM_DMA_BUS_CONFLICT_EN: blocked CPU reads during a DMA copy return the byte DMA is fetching.
module oam_dma_bus #(
  parameter int          DMA_LEN      = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int          START_DELAY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_enable,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] bus_addr,
  output logic        bus_enable,
  output logic        bus_write,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_write,
  output logic [7:0]  oam_wdata,
  output logic        dma_active,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX  = 8'(DMA_LEN - 1);
  localparam logic [7:0] START_CNT = 8'(START_DELAY);

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_tcyc;
  logic [7:0]  r_src;
  logic [7:0]  r_src_raw;
  logic [7:0]  r_idx;
  logic [7:0]  w_next_idx;
  logic [7:0]  r_cnt;
  logic [7:0]  w_next_cnt;
  logic        r_oam_write;
  logic [7:0]  r_oam_addr;
  logic [7:0]  r_oam_wdata;
  logic        w_t3;
  logic        w_reg_hit;
  logic        w_reg_wr;
  logic        w_high;

  assign w_t3      = (r_tcyc == 2'd3);
  assign w_reg_hit = cpu_enable && (cpu_addr == DMA_REG_ADDR);
  assign w_reg_wr  = w_reg_hit && cpu_write;
  assign w_high    = (cpu_addr >= 16'hFF00);

  // A register write on a t3 edge wins over every other transition.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_idx   = r_idx;
    if (w_t3) begin
      if (w_reg_wr) begin
        w_next_state = S_START;
        w_next_cnt   = START_CNT;
      end else begin
        case (r_state)
          S_START: begin
            if (r_cnt <= 8'd1) begin
              w_next_state = S_ACTIVE;
              w_next_cnt   = 8'd0;
              w_next_idx   = 8'd0;
            end else begin
              w_next_cnt = r_cnt - 8'd1;
            end
          end
          S_ACTIVE: begin
            if (r_idx == LAST_IDX) begin
              w_next_state = S_IDLE;
              w_next_idx   = 8'd0;
            end else begin
              w_next_idx = r_idx + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tcyc      <= 2'd0;
      r_src       <= 8'h00;
      r_src_raw   <= 8'h00;
      r_idx       <= 8'd0;
      r_cnt       <= 8'd0;
      r_oam_write <= 1'b0;
      r_oam_addr  <= 8'd0;
      r_oam_wdata <= 8'd0;
    end else begin
      r_tcyc      <= r_tcyc + 2'd1;
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_idx       <= w_next_idx;
      // The in-flight byte is always written, even when a restart lands on this edge.
      r_oam_write <= w_t3 && (r_state == S_ACTIVE);
      if (w_t3 && (r_state == S_ACTIVE)) begin
        r_oam_addr  <= r_idx;
        r_oam_wdata <= bus_rdata;
      end
      if (w_t3 && w_reg_wr) begin
        r_src_raw <= cpu_wdata;
        r_src     <= (cpu_wdata >= 8'hE0) ? (cpu_wdata & 8'hDF) : cpu_wdata;
      end
    end
  end

  always_comb begin
    bus_addr   = cpu_addr;
    bus_enable = 1'b0;
    bus_write  = 1'b0;
    bus_wdata  = cpu_wdata;
    cpu_rdata  = 8'hFF;
    if (r_state == S_ACTIVE) begin
      bus_addr   = {r_src, r_idx};
      bus_enable = 1'b1;
      bus_wdata  = 8'h00;
      if (cpu_enable && !cpu_write) begin
        if (w_reg_hit) begin
          cpu_rdata = r_src_raw;
        end
`ifdef OAM_DMA_BUS_CONFLICT_EN
        else if (!w_high) begin
          cpu_rdata = bus_rdata;
        end
`endif
      end
    end else if (cpu_enable) begin
      if (w_reg_hit) begin
        if (!cpu_write) cpu_rdata = r_src_raw;
      end else if ((r_state == S_IDLE) || w_high) begin
        bus_enable = 1'b1;
        bus_write  = cpu_write;
        cpu_rdata  = bus_rdata;
      end
    end
  end

  assign oam_write  = r_oam_write;
  assign oam_addr   = r_oam_addr;
  assign oam_wdata  = r_oam_wdata;
  assign dma_active = (r_state != S_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_oam_dma_bus.sv
// Bench for oam_dma_bus: passthrough vector table plus M-cycle-accurate DMA sequences with an OAM write scoreboard.
module tb_oam_dma_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_enable;
  logic        cpu_write;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic        bus_enable;
  logic        bus_write;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic [7:0]  oam_addr;
  logic        oam_write;
  logic [7:0]  oam_wdata;
  logic        dma_active;
  logic [1:0]  dbg_state;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  // Snapshot of outputs taken in the first clk of each M-cycle.
  logic [15:0] s_bus_addr;
  logic        s_bus_enable, s_bus_write, s_oam_write, s_dma_active;
  logic [7:0]  s_bus_wdata, s_cpu_rdata, s_oam_addr, s_oam_wdata;

  assign bus_rdata = mem[bus_addr];

  oam_dma_bus dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_enable(cpu_enable), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .bus_addr(bus_addr), .bus_enable(bus_enable), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .oam_addr(oam_addr), .oam_write(oam_write), .oam_wdata(oam_wdata),
    .dma_active(dma_active), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one CPU access for a whole M-cycle (4 clks), snapshotting outputs in its first clk.
  task automatic m_cycle(input logic [15:0] a, input logic en, input logic wr, input logic [7:0] wd);
    cpu_addr = a; cpu_enable = en; cpu_write = wr; cpu_wdata = wd;
    @(negedge clk);
    s_bus_addr = bus_addr; s_bus_enable = bus_enable; s_bus_write = bus_write;
    s_bus_wdata = bus_wdata; s_cpu_rdata = cpu_rdata; s_oam_write = oam_write;
    s_oam_addr = oam_addr; s_oam_wdata = oam_wdata; s_dma_active = dma_active;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) m_cycle(16'h0000, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic push_xfer(input logic [7:0] src, input int n);
    logic [7:0] f;
    f = (src >= 8'hE0) ? (src & 8'hDF) : src;
    for (int i = 0; i < n; i++) exp_q.push_back({i[7:0], mem[{f, i[7:0]}]});
  endtask

  // Scoreboard: every OAM write pulse must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (oam_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL oam_unexpected actual addr=%0h data=%0h expected no write", oam_addr, oam_wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("oam_addr", oam_addr, e[15:8]);
        chk("oam_wdata", oam_wdata, e[7:0]);
      end
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic        en;
    logic        wr;
    logic [7:0]  wd;
    logic        e_en;
    logic        e_wr;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t vecs [8];
  logic [7:0] exp_conf;

  initial begin
    reset = 1'b1; cpu_addr = 16'h0000; cpu_enable = 1'b0; cpu_write = 1'b0; cpu_wdata = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 7 + 3);
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem[16'hC100 + 16'(i)] = 8'($urandom_range(0, 255));
      mem[16'hDE00 + 16'(i)] = 8'($urandom_range(0, 255));
    end
    mem[16'h0150] = 8'h3B; mem[16'hC123] = 8'h11; mem[16'h8000] = 8'hE7; mem[16'hFF80] = 8'h9C;

    vecs[0] = '{16'h0150, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h3B};
    vecs[1] = '{16'hC123, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h11};
    vecs[2] = '{16'h8000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hE7};
    vecs[3] = '{16'h0150, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF};
    vecs[4] = '{16'hFF46, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{16'hFF80, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h9C};
    vecs[6] = '{16'hFF80, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 8'h9C};
    vecs[7] = '{16'hC123, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 8'hFF};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_oam_write", oam_write, 1'b0);
    chk("rst_oam_addr", oam_addr, 8'h00);
    chk("rst_oam_wdata", oam_wdata, 8'h00);
    chk("rst_dma_active", dma_active, 1'b0);
    chk("rst_bus_enable", bus_enable, 1'b0);
    chk("rst_bus_write", bus_write, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
    chk("rst_state", dbg_state, 2'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Idle passthrough table
    for (int v = 0; v < 8; v++) begin
      m_cycle(vecs[v].addr, vecs[v].en, vecs[v].wr, vecs[v].wd);
      chk($sformatf("tbl%0d_bus_enable", v), s_bus_enable, vecs[v].e_en);
      chk($sformatf("tbl%0d_bus_write", v), s_bus_write, vecs[v].e_wr);
      chk($sformatf("tbl%0d_cpu_rdata", v), s_cpu_rdata, vecs[v].e_rd);
      if (vecs[v].e_en) begin
        chk($sformatf("tbl%0d_bus_addr", v), s_bus_addr, vecs[v].addr);
        chk($sformatf("tbl%0d_bus_wdata", v), s_bus_wdata, vecs[v].wd);
      end
    end

    // Full transfer from 0xC000 with timing checks
    push_xfer(8'hC0, 160);
    m_cycle(16'hFF46, 1'b1, 1'b1, 8'hC0);
    m_cycle(16'h0150, 1'b1, 1'b0, 8'h00);
    chk("start_dma_active", s_dma_active, 1'b1);
    chk("start_bus_enable", s_bus_enable, 1'b0);
    chk("start_blocked_rd", s_cpu_rdata, 8'hFF);
    idle(1);
    chk("idx0_bus_addr", s_bus_addr, 16'hC000);
    chk("idx0_bus_enable", s_bus_enable, 1'b1);
    chk("idx0_no_pulse", s_oam_write, 1'b0);
    idle(1);
    chk("first_pulse", s_oam_write, 1'b1);
    chk("first_pulse_addr", s_oam_addr, 8'h00);
    chk("first_pulse_data", s_oam_wdata, 8'h5A);
    idle(157);
    idle(1);
    chk("idx159_dma_active", s_dma_active, 1'b1);
    chk("idx159_bus_addr", s_bus_addr, 16'hC09F);
    idle(1);
    chk("done_dma_active", s_dma_active, 1'b0);
    chk("last_pulse_addr", s_oam_addr, 8'h9F);
    chk("last_pulse_data", s_oam_wdata, 8'hC5);

    // Echo-folded source, readback and blocked accesses during ACTIVE
    push_xfer(8'hFE, 160);
    m_cycle(16'hFF46, 1'b1, 1'b1, 8'hFE);
    m_cycle(16'hFF46, 1'b1, 1'b0, 8'h00);
    chk("reg_read_start", s_cpu_rdata, 8'hFE);
    chk("reg_read_no_bus", s_bus_enable, 1'b0);
    idle(1);
    chk("fold_bus_addr", s_bus_addr, 16'hDE00);
    idle(4);
`ifdef OAM_DMA_BUS_CONFLICT_EN
    exp_conf = mem[16'hDE05];
`else
    exp_conf = 8'hFF;
`endif
    m_cycle(16'h0150, 1'b1, 1'b0, 8'h00);
    chk("blocked_read", s_cpu_rdata, exp_conf);
    chk("blocked_read_addr", s_bus_addr, 16'hDE05);
    m_cycle(16'hC000, 1'b1, 1'b1, 8'h77);
    chk("blocked_write", s_bus_write, 1'b0);
    chk("blocked_write_addr", s_bus_addr, 16'hDE06);
    m_cycle(16'hFF80, 1'b1, 1'b0, 8'h00);
    chk("active_high_read", s_cpu_rdata, 8'hFF);
    m_cycle(16'hFF46, 1'b1, 1'b0, 8'h00);
    chk("reg_read_active", s_cpu_rdata, 8'hFE);
    idle(151);
    idle(1);
    chk("fe_done", s_dma_active, 1'b0);

    // Restart at idx 50, then a write on the final transfer edge
    push_xfer(8'hC0, 51);
    m_cycle(16'hFF46, 1'b1, 1'b1, 8'hC0);
    idle(51);
    push_xfer(8'hC1, 160);
    m_cycle(16'hFF46, 1'b1, 1'b1, 8'hC1);
    chk("restart_bus_addr", s_bus_addr, 16'hC032);
    idle(1);
    chk("restart_pulse_addr", s_oam_addr, 8'h32);
    chk("restart_start_active", s_dma_active, 1'b1);
    chk("restart_start_no_bus", s_bus_enable, 1'b0);
    idle(1);
    chk("restart_idx0_addr", s_bus_addr, 16'hC100);
    idle(158);
    push_xfer(8'hC0, 80);
    m_cycle(16'hFF46, 1'b1, 1'b1, 8'hC0);
    chk("final_bus_addr", s_bus_addr, 16'hC19F);
    idle(1);
    chk("simul_stays_active", s_dma_active, 1'b1);
    chk("simul_last_pulse", s_oam_addr, 8'h9F);
    idle(1);
    chk("simul_idx0_addr", s_bus_addr, 16'hC000);
    idle(79);

    // Reset in the idx 80 M-cycle
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_oam_write", oam_write, 1'b0);
    chk("mid_rst_oam_addr", oam_addr, 8'h00);
    chk("mid_rst_dma_active", dma_active, 1'b0);
    chk("mid_rst_bus_enable", bus_enable, 1'b0);
    chk("mid_rst_cpu_rdata", cpu_rdata, 8'hFF);
    @(posedge clk);
    #1 reset = 1'b0;
    m_cycle(16'hFF46, 1'b1, 1'b0, 8'h00);
    chk("post_rst_reg", s_cpu_rdata, 8'h00);
    idle(3);
    push_xfer(8'hC0, 160);
    m_cycle(16'hFF46, 1'b1, 1'b1, 8'hC0);
    idle(3);
    chk("post_rst_first_addr", s_oam_addr, 8'h00);
    chk("post_rst_first_wr", s_oam_write, 1'b1);
    idle(162);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
